// File: rtl/log2_share_pkg.sv
// rtl/log2_share_pkg.sv - shared constants and types for the log2 sharing arbiter
package log2_share_pkg;

    localparam int LOG2_LATENCY = 3;
    localparam int LOG2_IN_W    = 24;
    localparam int LOG2_OUT_W   = 12;

    typedef logic [LOG2_IN_W-1:0]  log2_in_t;
    typedef logic [LOG2_OUT_W-1:0] log2_out_t;

    // Operand 1.0 in 16.8 format: the idle value of the log input and the clamp floor
    localparam log2_in_t LOG2_ONE = 24'h000100;

    // Tag field widths; the id width depends on NUM_REQ and lives in the top
    localparam int TAG_VALID_W = 1;
    localparam int TAG_UF_W    = 1;

endpackage

// File: rtl/Log2highacc.sv
// rtl/Log2highacc.sv - 3-stage pipelined log2, 16.8 unsigned in, 4.8 out, 64-entry fraction LUT
module Log2highacc
    import log2_share_pkg::*;
(
    input  logic      clk,
    input  log2_in_t  din,
    output log2_out_t dout
);

    // round(256 * log2(1 + k/64)) for the six mantissa bits below the leading one
    localparam logic [7:0] FRAC_LUT [64] = '{
        8'd0,   8'd6,   8'd11,  8'd17,  8'd22,  8'd28,  8'd33,  8'd38,
        8'd44,  8'd49,  8'd54,  8'd59,  8'd63,  8'd68,  8'd73,  8'd78,
        8'd82,  8'd87,  8'd92,  8'd96,  8'd100, 8'd105, 8'd109, 8'd113,
        8'd118, 8'd122, 8'd126, 8'd130, 8'd134, 8'd138, 8'd142, 8'd146,
        8'd150, 8'd154, 8'd157, 8'd161, 8'd165, 8'd169, 8'd172, 8'd176,
        8'd179, 8'd183, 8'd186, 8'd190, 8'd193, 8'd197, 8'd200, 8'd203,
        8'd207, 8'd210, 8'd213, 8'd216, 8'd220, 8'd223, 8'd226, 8'd229,
        8'd232, 8'd235, 8'd238, 8'd241, 8'd244, 8'd247, 8'd250, 8'd253
    };

    log2_in_t   x_d, x_q;
    logic [4:0] msb;
    logic [3:0] int_d, int_q;
    logic [5:0] mant_d, mant_q;
    log2_out_t  y_d, y_q;

    // Leading-one search, integer part and normalised mantissa of the registered operand
    always_comb begin
        x_d = din;
        msb = '0;
        for (int i = 0; i < LOG2_IN_W; i++) begin
            if (x_q[i]) msb = 5'(i);
        end
        int_d  = 4'(msb - 5'd8);
        mant_d = 6'((x_q << (5'd23 - msb)) >> 17);
        y_d    = {int_q, FRAC_LUT[mant_q]};
    end

    // Pipeline registers; the unit has no reset and no stall
    always_ff @(posedge clk) begin
        x_q    <= x_d;
        int_q  <= int_d;
        mant_q <= mant_d;
        y_q    <= y_d;
    end

    assign dout = y_q;

endmodule

// File: rtl/log2_rr_pick.sv
// rtl/log2_rr_pick.sv - combinational round-robin picker starting one past the pointer
module log2_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int cand;

    // Walk candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); first valid one wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (en && !any && req[cand]) begin
                any         = 1'b1;
                idx         = ID_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/log2_share_arb.sv
// rtl/log2_share_arb.sv - round-robin sharing of one Log2highacc; optional clamp via LOG2_SHARE_CLAMP_EN
module log2_share_arb
    import log2_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][23:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       res_valid,
    output logic [11:0]              res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy
`ifdef LOG2_SHARE_CLAMP_EN
    ,
    output logic                     underflow
`endif
);

    localparam int LAST = LOG2_LATENCY - 1;

    typedef struct packed {
        logic            valid;
`ifdef LOG2_SHARE_CLAMP_EN
        logic            uf;
`endif
        logic [ID_W-1:0] id;
    } tag_t;

    tag_t            tag_d [LOG2_LATENCY];
    tag_t            tag_q [LOG2_LATENCY];
    logic [ID_W-1:0] ptr_d, ptr_q;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic [NUM_REQ-1:0] pick_grant;
    log2_in_t        log_in;
    log2_out_t       log_out;
    logic            new_uf;

    // Grants are suppressed during reset so req_ready reads 0 while reset_n is low
    log2_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (en & reset_n),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = pick_grant;

    // Operand mux: granted operand, or 1.0 on idle cycles
    always_comb begin
        log_in = LOG2_ONE;
        new_uf = 1'b0;
        if (pick_any) begin
            log_in = req_data[pick_idx];
`ifdef LOG2_SHARE_CLAMP_EN
            if (req_data[pick_idx] < LOG2_ONE) begin
                log_in = LOG2_ONE;
                new_uf = 1'b1;
            end
`endif
        end
    end

    Log2highacc u_log2 (
        .clk  (clk),
        .din  (log_in),
        .dout (log_out)
    );

    // Next tag pipeline and pointer: a tag or bubble enters every cycle, pointer follows grants
    always_comb begin
        tag_d[0]       = '0;
        tag_d[0].valid = pick_any;
        tag_d[0].id    = pick_any ? pick_idx : '0;
`ifdef LOG2_SHARE_CLAMP_EN
        tag_d[0].uf    = new_uf;
`endif
        for (int i = 1; i < LOG2_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        ptr_d = pick_any ? pick_idx : ptr_q;
    end

    // Tag shift register and pointer; reset discards everything in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LOG2_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            tag_q <= tag_d;
            ptr_q <= ptr_d;
        end
    end

    // Result strobe decode and in-flight indication
    always_comb begin
        res_valid = '0;
        if (tag_q[LAST].valid) res_valid[tag_q[LAST].id] = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < LOG2_LATENCY; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    assign res_id   = tag_q[LAST].id;
    assign res_data = log_out;

`ifdef LOG2_SHARE_CLAMP_EN
    assign underflow = tag_q[LAST].valid & tag_q[LAST].uf;
`else
    logic unused_uf;
    assign unused_uf = new_uf;
`endif

endmodule

// File: tb/tb_log2_share_arb.sv
// tb/tb_log2_share_arb.sv - scoreboard bench for log2_share_arb
module tb_log2_share_arb;
    import log2_share_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][23:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       res_valid;
    logic [11:0]              res_data;
    logic [ID_W-1:0]          res_id;
    logic                     busy;
    logic                     uf_obs;

    log2_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
`ifdef LOG2_SHARE_CLAMP_EN
        ,
        .underflow (uf_obs)
`endif
    );

`ifndef LOG2_SHARE_CLAMP_EN
    assign uf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        int          id;
        logic [11:0] data;
        bit          chk_data;
        bit          uf;
    } exp_t;

    typedef struct {
        int          c;
        int          id;
        logic [11:0] data;
        logic        uf;
    } seen_t;

    exp_t  sb[$];
    seen_t seen[$];

    function automatic logic [11:0] model_log2(input logic [23:0] x);
        int          p;
        logic [23:0] n;
        int          k;
        real         f;
        int          fr;
        if (x < 24'h000100) x = 24'h000100;
        p = 0;
        for (int i = 0; i < 24; i++) if (x[i]) p = i;
        n  = x << (23 - p);
        k  = int'(n[22:17]);
        f  = 256.0 * $ln(1.0 + real'(k) / 64.0) / $ln(2.0);
        fr = int'(f);
        return {4'(p - 8), 8'(fr)};
    endfunction

    // Scoreboard: record transfers, compare strobes when their due cycle arrives
    always @(negedge clk) begin
        exp_t  e;
        seen_t s;
        if (!reset_n) begin
            sb.delete();
            checks++;
            if (res_valid !== '0) begin
                failures++;
                $display("FAIL reset_strobe got=%b exp=0000", res_valid);
            end
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_strobe id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (res_valid !== '0) begin
                s.c = cyc; s.id = int'(res_id); s.data = res_data; s.uf = uf_obs;
                seen.push_back(s);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (res_valid !== 4'(1 << e.id) || res_id !== ID_W'(e.id) ||
                    (e.chk_data && res_data !== e.data)) begin
                    failures++;
                    $display("FAIL sb_result cyc=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                             cyc, res_valid, res_id, res_data, 4'(1 << e.id), e.id, e.data);
                end
`ifdef LOG2_SHARE_CLAMP_EN
                checks++;
                if (uf_obs !== e.uf) begin
                    failures++;
                    $display("FAIL sb_underflow cyc=%0d got=%b exp=%b", cyc, uf_obs, e.uf);
                end
`endif
            end else if (res_valid !== '0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d got=%b exp=0000", cyc, res_valid);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.due = cyc + 3;
                    e.id  = i;
                    e.data = model_log2(req_data[i]);
                    e.uf  = (req_data[i] < 24'h000100);
`ifdef LOG2_SHARE_CLAMP_EN
                    e.chk_data = 1'b1;
`else
                    e.chk_data = !e.uf;
`endif
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive_edge();
        reset_n   = 1'b0;
        req_valid = '0;
        en        = 1'b1;
        drive_edge();
        drive_edge();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout got busy=%b exp=0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        en        = 1'b1;
        req_valid = '1;
        req_data  = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || res_valid !== '0 || busy !== 1'b0 || res_id !== '0 || uf_obs !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b busy=%b id=%0d uf=%b exp all zero",
                     req_ready, res_valid, busy, res_id, uf_obs);
        end
        drive_edge();
        req_valid = '0;
        reset_n   = 1'b1;
    endtask

    task automatic test_single();
        logic [23:0] ops [3];
        logic [11:0] want [3];
        int g0;
        ops[0] = 24'h000100; ops[1] = 24'h000200; ops[2] = 24'h000180;
        want[0] = 12'h000;   want[1] = 12'h100;   want[2] = 12'h096;
        seen.delete();
        g0 = 0;
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            req_valid   = 4'b0001;
            req_data[0] = ops[i];
            @(negedge clk);
            if (i == 0) g0 = cyc;
            checks++;
            if (req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL single_ready%0d got=%b exp=0001", i, req_ready);
            end
        end
        drive_edge();
        req_valid = '0;
        wait_idle("single");
        checks++;
        if (seen.size() != 3) begin
            failures++;
            $display("FAIL single_count got=%0d exp=3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i].data !== want[i] || seen[i].id != 0 || seen[i].c != g0 + 3 + i) begin
                    failures++;
                    $display("FAIL single_result%0d got d=%h id=%0d cyc=%0d exp d=%h id=0 cyc=%0d",
                             i, seen[i].data, seen[i].id, seen[i].c, want[i], g0 + 3 + i);
                end
            end
        end
    endtask

    task automatic test_full_range();
        int g;
        seen.delete();
        drive_edge();
        req_valid   = 4'b0100;
        req_data[2] = 24'hFFFFFF;
        @(negedge clk);
        g = cyc;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL full_ready got=%b exp=0100", req_ready);
        end
        drive_edge();
        req_valid = '0;
        wait_idle("full");
        checks++;
        if (seen.size() != 1 || seen[0].data !== 12'hFFD || seen[0].id != 2 || seen[0].c != g + 3) begin
            failures++;
            $display("FAIL full_result got n=%0d d=%h id=%0d cyc=%0d exp n=1 d=FFD id=2 cyc=%0d",
                     seen.size(), seen.size() > 0 ? seen[0].data : 12'h0,
                     seen.size() > 0 ? seen[0].id : -1, seen.size() > 0 ? seen[0].c : -1, g + 3);
        end
    endtask

    task automatic test_rotation();
        int g0;
        apply_reset();
        seen.delete();
        g0 = 0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = 24'($urandom_range(24'hFFFFFF, 24'h000100));
        for (int i = 0; i < 16; i++) begin
            drive_edge();
            req_valid = '1;
            @(negedge clk);
            if (i == 0) g0 = cyc;
            checks++;
            if (req_ready !== 4'(1 << (i % NUM_REQ))) begin
                failures++;
                $display("FAIL rot_grant%0d got=%b exp=%b", i, req_ready, 4'(1 << (i % NUM_REQ)));
            end
        end
        drive_edge();
        req_valid = '0;
        wait_idle("rot");
        checks++;
        if (seen.size() != 16) begin
            failures++;
            $display("FAIL rot_count got=%0d exp=16", seen.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (seen[i].id != i % NUM_REQ || seen[i].c != g0 + 3 + i) begin
                    failures++;
                    $display("FAIL rot_strobe%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d",
                             i, seen[i].id, seen[i].c, i % NUM_REQ, g0 + 3 + i);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int g1;
        apply_reset();
        seen.delete();
        req_data[0] = 24'h012345;
        req_data[1] = 24'h000400;
        drive_edge();
        req_valid = 4'b0011;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL en_grant0 got=%b exp=0001", req_ready);
        end
        drive_edge();
        @(negedge clk);
        g1 = cyc;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL en_grant1 got=%b exp=0010", req_ready);
        end
        drive_edge();
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL en_low_ready cyc=%0d got=%b exp=0000", cyc, req_ready);
            end
            if (cyc == g1 + 3 || cyc == g1 + 4) begin
                checks++;
                if (busy !== (cyc == g1 + 3)) begin
                    failures++;
                    $display("FAIL en_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc == g1 + 3);
                end
            end
        end
        drive_edge();
        req_valid = '0;
        en = 1'b1;
        checks++;
        if (seen.size() != 2) begin
            failures++;
            $display("FAIL en_strobes got=%0d exp=2", seen.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            req_valid   = 4'b0001;
            req_data[0] = 24'($urandom_range(24'hFFFFFF, 24'h000100));
        end
        drive_edge();
        req_valid = '0;
        reset_n   = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== '0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b v=%b exp busy=0 v=0000", busy, res_valid);
        end
        drive_edge();
        reset_n   = 1'b1;
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first_grant got=%b exp=0001", req_ready);
        end
        drive_edge();
        req_valid = '0;
        wait_idle("mid");
        checks++;
        if (seen.size() != 1 || seen[0].id != 0) begin
            failures++;
            $display("FAIL mid_strobes got n=%0d exp n=1 id=0", seen.size());
        end
    endtask

    task automatic test_underflow();
        int g;
        seen.delete();
        drive_edge();
        req_valid   = 4'b0010;
        req_data[1] = 24'h000050;
        @(negedge clk);
        g = cyc;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL uf_ready got=%b exp=0010", req_ready);
        end
        drive_edge();
        req_valid = '0;
        wait_idle("uf");
        checks++;
        if (seen.size() != 1 || seen[0].id != 1 || seen[0].c != g + 3) begin
            failures++;
            $display("FAIL uf_timing got n=%0d exp n=1 id=1 cyc=%0d", seen.size(), g + 3);
        end
`ifdef LOG2_SHARE_CLAMP_EN
        else begin
            checks++;
            if (seen[0].data !== 12'h000 || seen[0].uf !== 1'b1) begin
                failures++;
                $display("FAIL uf_clamp got d=%h uf=%b exp d=000 uf=1", seen[0].data, seen[0].uf);
            end
        end
`endif
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        en        = 1'b1;
        reset_n   = 1'b0;
        test_reset();
        test_single();
        test_full_range();
        test_rotation();
        test_en_drop();
        test_reset_mid();
        test_underflow();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
